// File: rtl/track_pkg.sv
// rtl/track_pkg.sv - shared state enum, sensor count and one-hot decode for the track scanner
package track_pkg;

   localparam int NUM_SENSORS = 4;

   typedef enum logic [1:0] {IDLE, EMIT, SAMPLE, UPDATE} track_state_t;

   function automatic logic [NUM_SENSORS-1:0] onehot(input logic [1:0] idx);
      logic [NUM_SENSORS-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/track_deb.sv
// rtl/track_deb.sv - per-sensor debounce: output follows raw only after DEBOUNCE_N disagreeing frames
module track_deb
   import track_pkg::*;
#(
   parameter int DEBOUNCE_N = 3
) (
   input  logic clk2,
   input  logic rst_n,
   input  logic raw,
   input  logic upd,
   output logic stable,
   output logic stable_nxt
);

   logic [3:0] cnt;
   logic [3:0] cnt_nxt;

   always_comb begin
      cnt_nxt    = cnt;
      stable_nxt = stable;
      if (upd) begin
         if (raw == stable) begin
            cnt_nxt = '0;
         end else if (cnt + 4'd1 == 4'(DEBOUNCE_N)) begin
            stable_nxt = raw;
            cnt_nxt    = '0;
         end else begin
            cnt_nxt = cnt + 4'd1;
         end
      end
   end

   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         cnt    <= cnt_nxt;
         stable <= stable_nxt;
      end
   end

endmodule

// File: rtl/track_sense.sv
// rtl/track_sense.sv - IR track sensor scanner; line-lost detection enabled by TRACK_SENSE_LOST_EN
module track_sense
   import track_pkg::*;
#(
   parameter int SETTLE_CYC  = 50,
   parameter int DEBOUNCE_N  = 3,
   parameter int LOST_FRAMES = 100
) (
   input  logic                   clk2,
   input  logic                   rst_n,
   input  logic                   scan_en,
   input  logic                   ir_in,
   output logic [NUM_SENSORS-1:0] ir_led,
   output logic [NUM_SENSORS-1:0] DIN,
   output logic                   din_valid,
   output logic                   lost
);

   track_state_t             state, state_nxt;
   logic [1:0]               ch, ch_nxt;
   logic [15:0]              cnt, cnt_nxt;
   logic [NUM_SENSORS-1:0]   raw, raw_nxt;
   logic [NUM_SENSORS-1:0]   din_nxt;
   logic                     upd;

   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ch    <= '0;
         cnt   <= '0;
         raw   <= '0;
      end else begin
         state <= state_nxt;
         ch    <= ch_nxt;
         cnt   <= cnt_nxt;
         raw   <= raw_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ch_nxt    = ch;
      cnt_nxt   = cnt;
      raw_nxt   = raw;
      ir_led    = '0;
      upd       = 1'b0;
      case (state)
         IDLE: begin
            if (scan_en) begin
               state_nxt = EMIT;
               ch_nxt    = '0;
               cnt_nxt   = '0;
            end
         end
         EMIT: begin
            ir_led = onehot(ch);
            if (cnt == 16'(SETTLE_CYC - 1)) begin
               state_nxt = SAMPLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         SAMPLE: begin
            // emitter stays lit so the comparator output is still valid when captured
            ir_led      = onehot(ch);
            raw_nxt[ch] = ir_in;
            if (ch == 2'd3) begin
               state_nxt = UPDATE;
            end else begin
               state_nxt = EMIT;
               ch_nxt    = ch + 2'd1;
            end
         end
         UPDATE: begin
            upd       = 1'b1;
            ch_nxt    = '0;
            state_nxt = scan_en ? EMIT : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign din_valid = upd;

   for (genvar k = 0; k < NUM_SENSORS; k++) begin : g_deb
      track_deb #(.DEBOUNCE_N(DEBOUNCE_N)) u_deb (
         .clk2       (clk2),
         .rst_n      (rst_n),
         .raw        (raw[k]),
         .upd        (upd),
         .stable     (DIN[k]),
         .stable_nxt (din_nxt[k])
      );
   end

`ifdef TRACK_SENSE_LOST_EN
   logic [9:0] lost_cnt;

   // judged on the post-debounce vector so lost moves in the same UPDATE as DIN
   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         lost_cnt <= '0;
      end else if (upd) begin
         if (din_nxt != '0) begin
            lost_cnt <= '0;
         end else if (lost_cnt != 10'(LOST_FRAMES)) begin
            lost_cnt <= lost_cnt + 10'd1;
         end
      end
   end

   assign lost = (lost_cnt == 10'(LOST_FRAMES));
`else
   logic unused_din_nxt;
   assign unused_din_nxt = ^din_nxt;
   assign lost           = 1'b0;
`endif

endmodule
